// File: rtl/audio_pkg.sv
// Shared audio datapath types and fixed-point constants used by the effect stages.
package audio_pkg;

    localparam int unsigned AUDIO_IN_W   = 16;
    localparam int unsigned AUDIO_COEF_W = 14;
    localparam int unsigned AUDIO_SCALE  = 5;
    localparam int unsigned AUDIO_PROD_W = AUDIO_IN_W + AUDIO_COEF_W;
    localparam int unsigned AUDIO_OUT_W  = AUDIO_PROD_W + 1;

    typedef logic signed [AUDIO_IN_W-1:0]   sample_t;
    typedef logic signed [AUDIO_COEF_W-1:0] coef_t;
    typedef logic signed [AUDIO_PROD_W-1:0] prod_t;
    typedef logic signed [AUDIO_OUT_W-1:0]  acc_t;

    localparam coef_t COEF_UNITY = coef_t'(1 << AUDIO_SCALE);

endpackage

// File: rtl/dual_gain_mix_gain_shadow.sv
// Shadow/active gain pair: new gains wait in shadow until the next accepted sample.
module gain_shadow
    import audio_pkg::*;
#(
    parameter int unsigned COEF_W = AUDIO_COEF_W,
    parameter int unsigned SCALE  = AUDIO_SCALE
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     gain_load,
    input  logic signed [COEF_W-1:0] g_dry_in,
    input  logic signed [COEF_W-1:0] g_wet_in,
    input  logic                     commit,
    output logic signed [COEF_W-1:0] g_dry_use,
    output logic signed [COEF_W-1:0] g_wet_use,
    output logic                     gain_pending
);

    localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1 << SCALE);

    logic signed [COEF_W-1:0] act_dry, act_wet;
    logic signed [COEF_W-1:0] sh_dry, sh_wet;

    // The committing sample must already see the shadow values, so bypass combinationally.
    always_comb begin
        g_dry_use = act_dry;
        g_wet_use = act_wet;
        if (gain_pending) begin
            g_dry_use = sh_dry;
            g_wet_use = sh_wet;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_dry      <= UNITY;
            act_wet      <= '0;
            sh_dry       <= UNITY;
            sh_wet       <= '0;
            gain_pending <= 1'b0;
        end else begin
            if (commit && gain_pending) begin
                act_dry <= sh_dry;
                act_wet <= sh_wet;
            end
            if (gain_load) begin
                sh_dry       <= g_dry_in;
                sh_wet       <= g_wet_in;
                gain_pending <= 1'b1;
            end else if (commit) begin
                gain_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dual_gain_mix.sv
// Two-stage pipelined dry/wet gain mixer feeding the round/clip stage at full precision.
module dual_gain_mix
    import audio_pkg::*;
#(
    parameter int unsigned IN_W   = AUDIO_IN_W,
    parameter int unsigned COEF_W = AUDIO_COEF_W,
    parameter int unsigned SCALE  = AUDIO_SCALE,
    parameter int unsigned OUT_W  = AUDIO_OUT_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IN_W-1:0]   in_dry,
    input  logic signed [IN_W-1:0]   in_wet,
    input  logic signed [COEF_W-1:0] g_dry_in,
    input  logic signed [COEF_W-1:0] g_wet_in,
    input  logic                     gain_load,
    output logic                     gain_pending,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data
);

    localparam int unsigned PROD_W = IN_W + COEF_W;

    if (OUT_W != IN_W + COEF_W + 1) begin : g_bad_width
        $error("dual_gain_mix: OUT_W must equal IN_W+COEF_W+1");
    end

    logic                     s1_valid;
    logic                     s1_load, s2_load, in_hs;
    logic signed [PROD_W-1:0] p_dry, p_wet;
    logic signed [COEF_W-1:0] g_dry, g_wet;
    logic signed [PROD_W-1:0] dry_ext, wet_ext, gd_ext, gw_ext;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = reset_n && s1_load;
    assign in_hs    = in_valid && in_ready;

    gain_shadow #(
        .COEF_W (COEF_W),
        .SCALE  (SCALE)
    ) u_gain_shadow (
        .clk          (clk),
        .reset_n      (reset_n),
        .gain_load    (gain_load),
        .g_dry_in     (g_dry_in),
        .g_wet_in     (g_wet_in),
        .commit       (in_hs),
        .g_dry_use    (g_dry),
        .g_wet_use    (g_wet),
        .gain_pending (gain_pending)
    );

    // Operands widened to product width so the multiply is exact and signed.
    assign dry_ext = PROD_W'(in_dry);
    assign wet_ext = PROD_W'(in_wet);
    assign gd_ext  = PROD_W'(g_dry);
    assign gw_ext  = PROD_W'(g_wet);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            p_dry    <= '0;
            p_wet    <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                p_dry <= dry_ext * gd_ext;
                p_wet <= wet_ext * gw_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= OUT_W'(p_dry) + OUT_W'(p_wet);
            end
        end
    end

endmodule

// File: tb/tb_dual_gain_mix.sv
// Randomized and directed bench for dual_gain_mix against a queue-based mix model.
module tb_dual_gain_mix;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               in_valid, in_ready;
    logic signed [15:0] in_dry, in_wet;
    logic signed [13:0] g_dry_in, g_wet_in;
    logic               gain_load, gain_pending;
    logic               out_valid, out_ready;
    logic signed [30:0] out_data;

    dual_gain_mix dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dry       (in_dry),
        .in_wet       (in_wet),
        .g_dry_in     (g_dry_in),
        .g_wet_in     (g_wet_in),
        .gain_load    (gain_load),
        .gain_pending (gain_pending),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint val;
        int     acc;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    longint m_act_d, m_act_w, m_sh_d, m_sh_w;
    logic   m_pend;
    logic   stalled_prev;
    longint prev_data;
    longint last_out;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_act_d = 32; m_act_w = 0;
        m_sh_d  = 32; m_sh_w  = 0;
        m_pend  = 1'b0;
        stalled_prev = 1'b0;
    endtask

    task automatic cycle(input logic v, input logic signed [15:0] d, input logic signed [15:0] w,
                         input logic gl, input logic signed [13:0] gd, input logic signed [13:0] gw,
                         input logic ordy, output logic acc);
        logic exp_rdy, exp_ov;
        in_valid = v; in_dry = d; in_wet = w;
        gain_load = gl; g_dry_in = gd; g_wet_in = gw;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = !(q.size() == 2 && !ordy);
        exp_ov  = (q.size() > 0) && (cyc - q[0].acc >= 2);
        check("in_ready", longint'(in_ready), longint'(exp_rdy));
        check("out_valid", longint'(out_valid), longint'(exp_ov));
        check("gain_pending", longint'(gain_pending), longint'(m_pend));
        if (stalled_prev) check("stall_hold", longint'(out_data), prev_data);
        if (out_valid && ordy && q.size() > 0) begin
            check("out_data", longint'(out_data), q[0].val);
            last_out = longint'(out_data);
            void'(q.pop_front());
        end
        acc = v && in_ready;
        if (acc) begin
            if (m_pend) begin
                m_act_d = m_sh_d; m_act_w = m_sh_w; m_pend = 1'b0;
            end
            q.push_back('{val: longint'(d) * m_act_d + longint'(w) * m_act_w, acc: cyc});
        end
        if (gl) begin
            m_sh_d = longint'(gd); m_sh_w = longint'(gw); m_pend = 1'b1;
        end
        stalled_prev = out_valid && !ordy;
        prev_data    = longint'(out_data);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        logic a;
        cycle(1'b0, '0, '0, 1'b0, '0, '0, ordy, a);
    endtask

    task automatic flush();
        for (int i = 0; i < 10 && q.size() > 0; i++) idle(1'b1);
        check("drain", longint'(q.size()), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_gain_pending", longint'(gain_pending), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic a;
        int   idx;
        logic signed [15:0] sd, sw;
        reset_n = 1'b0;
        in_valid = 1'b0; in_dry = '0; in_wet = '0;
        gain_load = 1'b0; g_dry_in = '0; g_wet_in = '0; out_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Unity default gains
        cycle(1'b1, 16'sh1234, 16'sh7FFF, 1'b0, '0, '0, 1'b1, a);
        flush();
        check("unity_const", last_out, 64'h0002_4680);

        // Mix gains
        cycle(1'b0, '0, '0, 1'b1, 14'sd16, 14'sd16, 1'b1, a);
        cycle(1'b1, 16'sd1000, -16'sd200, 1'b0, '0, '0, 1'b1, a);
        flush();
        check("mix_const", last_out, 12800);
        cycle(1'b0, '0, '0, 1'b1, 14'sd16, -14'sd32, 1'b1, a);
        cycle(1'b1, 16'sd500, 16'sd1, 1'b0, '0, '0, 1'b1, a);
        flush();
        check("mix_neg_const", last_out, 7968);

        // Extreme corner
        cycle(1'b0, '0, '0, 1'b1, -14'sd8192, -14'sd8192, 1'b1, a);
        cycle(1'b1, -16'sd32768, -16'sd32768, 1'b0, '0, '0, 1'b1, a);
        flush();
        check("extreme_const", last_out, 64'h2000_0000);

        // Gain update coincident with sample A, then sample B
        do_reset();
        cycle(1'b1, 16'sd100, 16'sd0, 1'b1, 14'sd64, 14'sd0, 1'b1, a);
        check("gt_pending_next", longint'(gain_pending), 1);
        cycle(1'b1, 16'sd100, 16'sd0, 1'b0, '0, '0, 1'b1, a);
        check("gt_pending_clr", longint'(gain_pending), 0);
        flush();
        check("gt_b_const", last_out, 6400);

        // Backpressure: 6 samples with a 4-cycle stall
        idx = 0;
        for (int t = 0; t < 40 && (idx < 6 || q.size() > 0); t++) begin
            cycle(idx < 6, 16'(idx * 111 - 300), 16'(idx * 7), 1'b0, '0, '0, !(t >= 2 && t < 6), a);
            if (a) idx++;
        end
        check("bp_accepted", longint'(idx), 6);
        check("bp_drained", longint'(q.size()), 0);

        // Reset in the middle of a stream
        cycle(1'b1, 16'sd5, 16'sd5, 1'b0, '0, '0, 1'b0, a);
        cycle(1'b1, 16'sd6, 16'sd6, 1'b0, '0, '0, 1'b0, a);
        do_reset();
        cycle(1'b1, 16'sd10, 16'sd10, 1'b0, '0, '0, 1'b1, a);
        flush();
        check("post_reset_const", last_out, 320);

        // Randomized traffic; data held until accepted
        sd = 16'($urandom); sw = 16'($urandom);
        for (int t = 0; t < 600; t++) begin
            cycle(1'($urandom_range(0, 3) != 0), sd, sw, 1'($urandom_range(0, 7) == 0),
                  14'($urandom), 14'($urandom), 1'($urandom_range(0, 3) != 0), a);
            if (a) begin
                sd = 16'($urandom); sw = 16'($urandom);
            end
        end
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
